// File: rtl/spi_tx_buffer_8lane.sv
// Memory-mapped 128-bit transmit buffer driving an 8-lane SPI master (MSB byte first).
// Optional macro SPI_TX_IRQ_EN adds the ie control bit and the level irq_tx output.
`timescale 1ns/1ps
module spi_tx_buffer_8lane #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0020,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [7:0]  spi_data,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_active,
  output logic        irq_tx
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE} state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t        state, state_nx;
  logic [7:0]    cnt;
  logic [3:0]    byte_idx;
  logic [127:0]  shift_q;
  logic [31:0]   data_q [4];
  logic          done_q;
  logic          ie;

  logic [31:0]   offset;
  logic [2:0]    word;
  logic          in_win, ack, wr, start, clr_done, ctrl_wr;
  logic          busy, phase_end, advance, in_frame_nx;
  logic [31:0]   rd_val;
  logic          unused_bits;

  assign offset      = mem_addr - BASE_ADDR;
  assign in_win      = (offset[31:5] == '0);
  assign word        = offset[4:2];
  assign unused_bits = ^offset[1:0];

  // Writes land at the end of the ack cycle, so a start shows up as SETUP one cycle after the ack.
  assign ack      = mem_valid & mem_ready;
  assign wr       = ack & in_win & (mem_wstrb != '0);
  assign ctrl_wr  = wr & (word == 3'd4) & mem_wstrb[0];
  assign start    = ctrl_wr & mem_wdata[0] & (state == IDLE);
  assign clr_done = wr & (word == 3'd5) & mem_wstrb[0] & mem_wdata[1];

  assign busy      = (state != IDLE);
  assign phase_end = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = SETUP;
      SETUP:    if (phase_end) state_nx = SHIFT_HI;
      SHIFT_HI: if (phase_end) begin
                  if (byte_idx == 4'd15) state_nx = HOLD;
                  else begin
                    state_nx = SHIFT_LO;
                    advance  = 1'b1;
                  end
                end
      SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
      HOLD:     if (phase_end) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign in_frame_nx = (state_nx == SETUP) || (state_nx == SHIFT_HI) ||
                       (state_nx == SHIFT_LO) || (state_nx == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      byte_idx   <= '0;
      shift_q    <= '0;
      spi_data   <= '0;
      spi_clk    <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_active <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      if (state_nx != state)   cnt <= DIV_RELOAD;
      else if (cnt != '0)      cnt <= cnt - 8'd1;

      if (start) begin
        shift_q  <= {data_q[0], data_q[1], data_q[2], data_q[3]};
        spi_data <= data_q[0][31:24];
        byte_idx <= '0;
      end else if (advance) begin
        shift_q  <= {shift_q[119:0], 8'h00};
        spi_data <= shift_q[119:112];
        byte_idx <= byte_idx + 4'd1;
      end

      spi_clk    <= (state_nx == SHIFT_HI);
      spi_cs_n   <= ~in_frame_nx;
      spi_active <= in_frame_nx;

      // Setting on DONE entry has priority over a coincident software clear.
      if ((state_nx == DONE) && (state != DONE)) done_q <= 1'b1;
      else if (start || clr_done)                done_q <= 1'b0;

      if (wr && (word < 3'd4)) begin
        for (int unsigned b = 0; b < 4; b++)
          if (mem_wstrb[b]) data_q[word[1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef SPI_TX_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ie <= 1'b0;
    else if (ctrl_wr) ie <= mem_wdata[1];
  end
  assign irq_tx = done_q & ie;
`else
  assign ie     = 1'b0;
  assign irq_tx = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    if (in_win) begin
      case (word)
        3'd0, 3'd1, 3'd2, 3'd3: rd_val = data_q[word[1:0]];
        3'd4:    rd_val = {30'b0, ie, 1'b0};
        3'd5:    rd_val = {30'b0, done_q, busy};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= mem_valid & ~mem_ready;
      if (mem_valid && !mem_ready) mem_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_spi_tx_buffer_8lane.sv
// Bench for spi_tx_buffer_8lane: register table, directed frame sequences and random frames
// checked against a byte-level model of the register file.
`timescale 1ns/1ps
module tb_spi_tx_buffer_8lane;

  localparam logic [31:0] BASE    = 32'h3000_0020;
  localparam int unsigned CLK_DIV = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_valid = 1'b0, mem_ready;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic [7:0]  spi_data;
  logic        spi_clk, spi_cs_n, spi_active, irq_tx;

  spi_tx_buffer_8lane #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .spi_data(spi_data), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_active(spi_active),
    .irq_tx(irq_tx)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;
  logic [31:0] model [4];
  logic [7:0]  exp_bytes [16];

  // Frame monitor
  logic [7:0]  got [$];
  int unsigned lo_cnt = 0;
  bit          seen_low = 0, frame_done = 0, irq_seen = 0, prev_sclk = 0;

  always @(negedge clk) begin
    if (!spi_cs_n) begin lo_cnt++; seen_low = 1; end
    else if (seen_low) frame_done = 1;
    if (spi_clk && !prev_sclk) got.push_back(spi_data);
    prev_sclk = spi_clk;
    if (irq_tx) irq_seen = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st);
    if (off < 8'h10)
      for (int b = 0; b < 4; b++)
        if (st[b]) model[off / 4][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic bus(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd);
    int unsigned n = 0;
    rd = '0;
    mem_addr = BASE + 32'(off); mem_wdata = wd; mem_wstrb = st; mem_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!mem_ready && n < 20);
    if (!mem_ready) begin
      n_checks++; n_fail++;
      $display("FAIL bus_timeout: no ack for offset %h after %0d cycles", off, n);
    end else rd = mem_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
    if (st != '0) model_write(off, wd, st);
  endtask

  task automatic start_frame(input logic [31:0] ctrl);
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'(model[i / 4] >> (24 - 8 * (i % 4)));
    got.delete(); lo_cnt = 0; seen_low = 0; frame_done = 0;
    bus(8'h10, ctrl, 4'hF, rd);
  endtask

  task automatic finish_frame(input string tag);
    int unsigned n = 0;
    while (!frame_done && n < 2000) begin @(posedge clk); #1; n++; end
    chk({tag, "_frame_end"}, 32'(frame_done), 32'd1);
    chk({tag, "_nbytes"}, got.size(), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_bytes[i]));
    chk({tag, "_cs_low_cycles"}, lo_cnt, 33 * CLK_DIV);
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp;
    bit          rd_chk;
    string       name;
  } vec_t;

  initial begin
    vec_t        tbl [$];
    logic [31:0] rd;
    int unsigned n;

    tbl.push_back('{8'h14, 32'h0, 4'h0, 32'h0, 1, "rst_status"});
    tbl.push_back('{8'h00, 32'h0, 4'h0, 32'h0, 1, "rst_data0"});
    tbl.push_back('{8'h10, 32'h0, 4'h0, 32'h0, 1, "rst_ctrl"});
    tbl.push_back('{8'h00, 32'h0011_2233, 4'hF, 32'h0, 0, "wr_data0"});
    tbl.push_back('{8'h04, 32'h4455_6677, 4'hF, 32'h0, 0, "wr_data1"});
    tbl.push_back('{8'h08, 32'h8899_AABB, 4'hF, 32'h0, 0, "wr_data2"});
    tbl.push_back('{8'h0C, 32'hCCDD_EEFF, 4'hF, 32'h0, 0, "wr_data3"});
    tbl.push_back('{8'h00, 32'h0, 4'h0, 32'h0011_2233, 1, "rd_data0"});
    tbl.push_back('{8'h0C, 32'h0, 4'h0, 32'hCCDD_EEFF, 1, "rd_data3"});
    tbl.push_back('{8'h1C, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, "wr_unmapped"});
    tbl.push_back('{8'h1C, 32'h0, 4'h0, 32'h0, 1, "rd_unmapped"});
    tbl.push_back('{8'h18, 32'h0, 4'h0, 32'h0, 1, "rd_unmapped18"});

    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_active", 32'(spi_active), 32'd0);
    chk("rst_spi_data", 32'(spi_data), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      bus(tbl[i].off, tbl[i].wd, tbl[i].st, rd);
      if (tbl[i].rd_chk) chk(tbl[i].name, rd, tbl[i].exp);
    end

    // Directed frame with mid-frame restart attempt and DATA0 overwrite
    start_frame(32'h1);
    repeat (5) @(posedge clk);
    #1;
    bus(8'h10, 32'h1, 4'hF, rd);
    bus(8'h00, 32'hFFFF_FFFF, 4'hF, rd);
    bus(8'h14, 32'h0, 4'h0, rd);
    chk("mid_status_busy", rd, 32'h1);
    finish_frame("f1");
    repeat (20) @(posedge clk);
    #1;
    chk("no_restart_cs", 32'(spi_cs_n), 32'd1);
    chk("no_restart_bytes", got.size(), 32'd16);
    chk("hold_last_byte", 32'(spi_data), 32'hFF);
    bus(8'h14, 32'h0, 4'h0, rd); chk("status_done", rd, 32'h2);
    bus(8'h00, 32'h0, 4'h0, rd); chk("data0_after", rd, 32'hFFFF_FFFF);
    bus(8'h14, 32'h2, 4'hF, rd);
    bus(8'h14, 32'h0, 4'h0, rd); chk("status_cleared", rd, 32'h0);
    bus(8'h04, 32'hAABB_CCDD, 4'b0010, rd);
    bus(8'h04, 32'h0, 4'h0, rd); chk("partial_strobe", rd, 32'h4455_CC77);
    chk("partial_model", rd, model[1]);

    // Reset on the 5th rising spi_clk edge
    start_frame(32'h1);
    n = 0;
    while (!(spi_clk && got.size() == 4) && n < 500) begin @(posedge clk); #1; n++; end
    chk("reach_5th_edge", 32'(n < 500), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_mid_active", 32'(spi_active), 32'd0);
    chk("rst_mid_sclk", 32'(spi_clk), 32'd0);
    chk("rst_mid_busy", 32'(dut.state != dut.IDLE), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge clk); #1;
    bus(8'h14, 32'h0, 4'h0, rd); chk("post_rst_status", rd, 32'h0);
    bus(8'h08, 32'h0, 4'h0, rd); chk("post_rst_data2", rd, 32'h0);
    for (int w = 0; w < 4; w++) bus(8'(4 * w), $urandom, 4'hF, rd);
    start_frame(32'h1);
    finish_frame("after_rst");

    // Random data with random strobe patterns
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 6; k++)
        bus(8'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)), rd);
      n = $urandom_range(0, 3);
      bus(8'(4 * n), 32'h0, 4'h0, rd);
      chk($sformatf("rnd%0d_readback", it), rd, model[n]);
      start_frame(32'h1);
      finish_frame($sformatf("rnd%0d", it));
    end

    // Interrupt behaviour
    irq_seen = 0;
    start_frame(32'h3);
    finish_frame("irq_frame");
    @(posedge clk); #1;
`ifdef SPI_TX_IRQ_EN
    chk("irq_high", 32'(irq_tx), 32'd1);
    bus(8'h10, 32'h0, 4'h0, rd); chk("ctrl_ie", rd, 32'h2);
    bus(8'h14, 32'h2, 4'hF, rd);
    chk("irq_cleared", 32'(irq_tx), 32'd0);
`else
    bus(8'h10, 32'h0, 4'h0, rd); chk("ctrl_no_ie", rd, 32'h0);
    chk("irq_never", 32'(irq_seen), 32'd0);
    chk("irq_low", 32'(irq_tx), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
